// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int BW_DEF      = 10;
  localparam int TIMEOUT_DEF = 255;

  // Port indices: port 0 is the UART debug MCU, port 1 the user datapath.
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_port_arb_if.sv
// Bundle of client-port and SDRAM-controller signals around the arbiter.
// master = the arbiter's view, slave = clients plus controller.
interface sdram_port_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int BW = 10
);
  logic          m0_req, m0_we, m0_wack, m0_rvalid, m0_done, m0_err;
  logic [AW-1:0] m0_addr;
  logic [BW-1:0] m0_burst;
  logic [DW-1:0] m0_wdata, m0_rdata;

  logic          m1_req, m1_we, m1_wack, m1_rvalid, m1_done, m1_err;
  logic [AW-1:0] m1_addr;
  logic [BW-1:0] m1_burst;
  logic [DW-1:0] m1_wdata, m1_rdata;

  logic          sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [BW-1:0] sdram_wr_burst, sdram_rd_burst;
  logic [DW-1:0] sdram_din, sdram_dout;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_burst, m0_wdata,
    output m0_wack, m0_rdata, m0_rvalid, m0_done, m0_err,
    input  m1_req, m1_we, m1_addr, m1_burst, m1_wdata,
    output m1_wack, m1_rdata, m1_rvalid, m1_done, m1_err,
    output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
    output sdram_wr_burst, sdram_rd_burst, sdram_din,
    input  sdram_wr_ack, sdram_rd_ack, sdram_dout
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_burst, m0_wdata,
    input  m0_wack, m0_rdata, m0_rvalid, m0_done, m0_err,
    output m1_req, m1_we, m1_addr, m1_burst, m1_wdata,
    input  m1_wack, m1_rdata, m1_rvalid, m1_done, m1_err,
    input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
    input  sdram_wr_burst, sdram_rd_burst, sdram_din,
    output sdram_wr_ack, sdram_rd_ack, sdram_dout
  );
endinterface

// File: rtl/sdram_arb_rr.sv
// Two-request round-robin pick: on a tie the port that did not win last goes.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  // Lone requester wins outright; a tie goes to the other port.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = P0;
    if (req == 2'b11)  gnt_idx = ~last_grant;
    else if (req[1])   gnt_idx = P1;
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port burst arbiter/sequencer in front of a single SDRAM controller.
// Grants one whole burst at a time, counts per-word acks, returns strobes,
// read data and a done pulse per port.
// Optional: define SDRAM_ARB_TIMEOUT_EN for an ack watchdog that aborts a
// stalled burst (done with err); otherwise the burst waits forever, err=0.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int BW      = BW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  sdram_port_arb_if.master bus
);

  state_t state_q, state_d;

  logic [1:0]         req, req_m, we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][BW-1:0] burst;
  logic [1:0][DW-1:0] wdata;

  logic               pick_vld, pick_idx;
  logic               grant, ack_hit, last_word, abort, tmo;

  logic               gnt_q, we_q, last_grant_q;
  logic [BW-1:0]      cnt_q, burst_q;
  logic               wr_req_q, rd_req_q;
  logic [AW-1:0]      wr_addr_q, rd_addr_q;
  logic [BW-1:0]      wr_burst_q, rd_burst_q;
  logic [1:0]         wack_q, rvalid_q, done_q, err_q;
  logic [1:0][DW-1:0] rdata_q;

  assign req   = {bus.m1_req,   bus.m0_req};
  assign we    = {bus.m1_we,    bus.m0_we};
  assign addr  = {bus.m1_addr,  bus.m0_addr};
  assign burst = {bus.m1_burst, bus.m0_burst};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};

  // A port whose done pulse is out is still holding req; keep it from re-winning.
  assign req_m = req & ~done_q;

  sdram_arb_rr u_rr (
    .req        (req_m),
    .last_grant (last_grant_q),
    .gnt_vld    (pick_vld),
    .gnt_idx    (pick_idx)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state plus the per-cycle grant/ack/finish decisions.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    ack_hit   = 1'b0;
    last_word = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: if (pick_vld) begin
        grant   = 1'b1;
        state_d = (burst[pick_idx] == '0) ? DONE : XFER;
      end
      XFER: begin
        ack_hit   = we_q ? bus.sdram_wr_ack : bus.sdram_rd_ack;
        last_word = ack_hit && (cnt_q == burst_q - BW'(1));
        abort     = tmo && !ack_hit;
        if (last_word || abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, word counting, controller requests and client strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt_q        <= P0;
      we_q         <= 1'b0;
      last_grant_q <= P1;
      cnt_q        <= '0;
      burst_q      <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_burst_q   <= '0;
      rd_burst_q   <= '0;
      wack_q       <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      done_q       <= '0;
    end else begin
      wack_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
      if (grant) begin
        gnt_q   <= pick_idx;
        we_q    <= we[pick_idx];
        burst_q <= burst[pick_idx];
        cnt_q   <= '0;
        if (we[pick_idx]) begin
          wr_addr_q  <= addr[pick_idx];
          wr_burst_q <= burst[pick_idx];
          wr_req_q   <= (burst[pick_idx] != '0);
        end else begin
          rd_addr_q  <= addr[pick_idx];
          rd_burst_q <= burst[pick_idx];
          rd_req_q   <= (burst[pick_idx] != '0);
        end
      end
      if (ack_hit) begin
        cnt_q <= cnt_q + BW'(1);
        if (we_q) begin
          wack_q[gnt_q] <= 1'b1;
        end else begin
          rvalid_q[gnt_q] <= 1'b1;
          rdata_q[gnt_q]  <= bus.sdram_dout;
        end
      end
      if (last_word || abort) begin
        wr_req_q <= 1'b0;
        rd_req_q <= 1'b0;
      end
      if (state_q == DONE) begin
        done_q[gnt_q] <= 1'b1;
        last_grant_q  <= gnt_q;
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  // Fires on the edge the idle count would reach TIMEOUT.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);
  logic [7:0] wdog_q;
  logic       abort_q;

  assign tmo = (wdog_q == TO_LIM);

  // Watchdog: restarts on grant and every honoured ack, runs only in XFER.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= '0;
    end else begin
      err_q <= '0;
      if (grant)                 abort_q <= 1'b0;
      if (abort)                 abort_q <= 1'b1;
      if (state_q != XFER || ack_hit) wdog_q <= '0;
      else                       wdog_q <= wdog_q + 8'd1;
      if (state_q == DONE)       err_q[gnt_q] <= abort_q;
    end
  end
`else
  assign tmo   = 1'b0;
  assign err_q = '0;
`endif

  assign bus.sdram_wr_req   = wr_req_q;
  assign bus.sdram_rd_req   = rd_req_q;
  assign bus.sdram_wr_addr  = wr_addr_q;
  assign bus.sdram_rd_addr  = rd_addr_q;
  assign bus.sdram_wr_burst = wr_burst_q;
  assign bus.sdram_rd_burst = rd_burst_q;
  assign bus.sdram_din      = wdata[gnt_q];

  assign bus.m0_wack   = wack_q[0];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m0_done   = done_q[0];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_wack   = wack_q[1];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.m1_done   = done_q[1];
  assign bus.m1_err    = err_q[1];

endmodule
